// File: rtl/can_bus_pkg.sv
// Shared types, default timing and pin-decode helper for the CAN controller muxed-bus bridge.
package can_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    STROBE,
    RECOVER,
    CHIP_RST
  } bus_state_e;

  localparam int DEF_ADDR_LSB = 2;
  localparam int DEF_ALE_CYC  = 3;
  localparam int DEF_HOLD_CYC = 1;
  localparam int DEF_STB_CYC  = 6;
  localparam int DEF_REC_CYC  = 2;
  localparam int DEF_CRST_CYC = 16;

  typedef struct packed {
    logic [7:0] ad;
    logic       sel;
    logic       cs_n;
    logic       ale;
    logic       wr_n;
    logic       rd_n;
    logic       rst_n;
  } bus_pins_t;

  localparam bus_pins_t PINS_IDLE = '{ad: 8'h00, sel: 1'b0, cs_n: 1'b1, ale: 1'b0,
                                      wr_n: 1'b1, rd_n: 1'b1, rst_n: 1'b1};
  localparam bus_pins_t PINS_RST  = '{ad: 8'h00, sel: 1'b0, cs_n: 1'b1, ale: 1'b0,
                                      wr_n: 1'b1, rd_n: 1'b1, rst_n: 1'b0};

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Pin levels for a given phase; rd selects the read/write flavour of the strobe.
  function automatic bus_pins_t pins_of(input bus_state_e s, input logic rd,
                                        input logic [7:0] a, input logic [7:0] d);
    bus_pins_t p;
    p = PINS_IDLE;
    case (s)
      ADDR: begin
        p.ale = 1'b1;
        p.ad  = a;
      end
      HOLD: p.ad = a;
      STROBE: begin
        p.cs_n = 1'b0;
        if (rd) begin
          p.rd_n = 1'b0;
          p.sel  = 1'b1;
        end else begin
          p.wr_n = 1'b0;
          p.ad   = d;
        end
      end
      RECOVER:  p.sel = rd;
      CHIP_RST: p = PINS_RST;
      default:  p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/can_int_sync.sv
// Two-flop synchroniser for the active-low chip interrupt plus a synchronised falling-edge strobe.
module can_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic int_n_i,
  output logic fall_o
);

  // [0],[1] form the synchroniser; [2] remembers the previous synchronised level.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= {sync_q[1:0], int_n_i};
  end

  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/can_muxbus_bridge.sv
// Single-cycle CPU read/write requests to a multiplexed address/data CAN controller bus,
// with chip-reset sequencing and a sticky, synchronised interrupt flag.
module can_muxbus_bridge
  import can_bus_pkg::*;
#(
  parameter int ADDR_LSB = DEF_ADDR_LSB,
  parameter int ALE_CYC  = DEF_ALE_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int STB_CYC  = DEF_STB_CYC,
  parameter int REC_CYC  = DEF_REC_CYC,
  parameter int CRST_CYC = DEF_CRST_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_32b_i,
  input  logic        wren_i,
  input  logic        rden_i,
  input  logic [31:0] din_32b_i,
  input  logic        chip_rst_req_i,
  input  logic        irq_clr_i,
  output logic [31:0] dout_32b_o,
  output logic        dout_32b_valid_o,
  output logic        busy_o,
  output logic        irq_o,
  input  logic [7:0]  can_ad_i,
  output logic [7:0]  can_ad_o,
  output logic        can_ad_sel,
  output logic        can_cs_n,
  output logic        can_ale,
  output logic        can_wr_n,
  output logic        can_rd_n,
  output logic        can_rst_n,
  input  logic        can_int_n
);

  localparam int MAXC = max_of(max_of(max_of(ALE_CYC, HOLD_CYC), max_of(STB_CYC, REC_CYC)), CRST_CYC);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  if (ALE_CYC < 1 || HOLD_CYC < 1 || STB_CYC < 1 || REC_CYC < 1 || CRST_CYC < 1) begin : g_bad_cyc
    $error("can_muxbus_bridge: every cycle parameter must be >= 1");
  end
  if (ADDR_LSB < 0 || ADDR_LSB > 24) begin : g_bad_lsb
    $error("can_muxbus_bridge: ADDR_LSB must leave 8 address bits inside addr_32b_i");
  end

  bus_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          pend_q, pend_d;
  bus_pins_t     pins_q, pins_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [7:0]    dout_q, dout_d;
  logic          irq_q, irq_d;
  logic          int_fall;

  can_int_sync u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .int_n_i (can_int_n),
    .fall_o  (int_fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    rd_d    = rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = pend_q | chip_rst_req_i;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A pending chip reset wins over a same-cycle access; the access is dropped.
        if (pend_d) begin
          state_d = CHIP_RST;
          pend_d  = 1'b0;
          rd_d    = 1'b0;
        end else if (wren_i | rden_i) begin
          state_d = ADDR;
          rd_d    = rden_i;
          addr_d  = addr_32b_i[ADDR_LSB +: 8];
          data_d  = din_32b_i[7:0];
        end
      end
      ADDR: if (cnt_q == CW'(ALE_CYC - 1)) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: if (cnt_q == CW'(HOLD_CYC - 1)) begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: if (cnt_q == CW'(STB_CYC - 1)) begin
        state_d = RECOVER;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
      RECOVER: if (cnt_q == CW'(REC_CYC - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      CHIP_RST: if (cnt_q == CW'(CRST_CYC - 1)) begin
        state_d = RECOVER;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Read data is taken on the edge that ends the last strobe cycle.
    dout_d = dout_q;
    if (valid_d) dout_d = rd_q ? can_ad_i : 8'h00;

    // Pins are registered from the next state so they toggle cleanly with the state.
    pins_d = pins_of(state_d, rd_d, addr_d, data_d);
    busy_d = (state_d != IDLE);
    irq_d  = int_fall | (irq_q & ~irq_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHIP_RST;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      pend_q  <= 1'b0;
      pins_q  <= PINS_RST;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      dout_q  <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      pins_q  <= pins_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
    end
  end

  assign can_ad_o         = pins_q.ad;
  assign can_ad_sel       = pins_q.sel;
  assign can_cs_n         = pins_q.cs_n;
  assign can_ale          = pins_q.ale;
  assign can_wr_n         = pins_q.wr_n;
  assign can_rd_n         = pins_q.rd_n;
  assign can_rst_n        = pins_q.rst_n;
  assign busy_o           = busy_q;
  assign irq_o            = irq_q;
  assign dout_32b_valid_o = valid_q;
  assign dout_32b_o       = {24'h000000, dout_q};

  logic unused_in;
  assign unused_in = ^{addr_32b_i, din_32b_i[31:8]};

endmodule

// File: doc/can_muxbus_bridge.md
CAN_MUXBUS_BRIDGE -- requirements
Module: can_muxbus_bridge

Interface
REQ-001 SHALL have parameter ADDR_LSB, default 2, meaning lowest addr_32b_i bit mapped to bus address bit 0.
REQ-002 SHALL have parameter ALE_CYC, default 3, meaning cycles ALE is high with the address driven.
REQ-003 SHALL have parameter HOLD_CYC, default 1, meaning cycles the address is held after ALE falls.
REQ-004 SHALL have parameter STB_CYC, default 6, meaning cycles the RD/WR strobe is low.
REQ-005 SHALL have parameter REC_CYC, default 2, meaning cycles of CS-high recovery before the next access.
REQ-006 SHALL have parameter CRST_CYC, default 16, meaning cycles can_rst_n is held low per chip reset.
REQ-007 SHALL have ports, one per line (name, direction, width, meaning):
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
addr_32b_i  in  32  CPU byte address
wren_i  in  1  write request, single-cycle
rden_i  in  1  read request, single-cycle
din_32b_i  in  32  write data, bits [7:0] used
chip_rst_req_i  in  1  request a chip reset pulse
irq_clr_i  in  1  clear sticky interrupt flag
dout_32b_o  out  32  read data {24'b0, byte}
dout_32b_valid_o  out  1  one-cycle completion pulse (read or write)
busy_o  out  1  high whenever not in IDLE
irq_o  out  1  sticky interrupt flag
can_ad_i  in  8  muxed bus input
can_ad_o  out  8  muxed bus output
can_ad_sel  out  1  1 = receive (pad tri-stated), 0 = drive
can_cs_n, can_ale, can_wr_n, can_rd_n, can_rst_n  out  1 each  chip controls
can_int_n  in  1  asynchronous chip interrupt, active-low

Function
REQ-008 SHALL implement states IDLE, ADDR, HOLD, STROBE, RECOVER, CHIP_RST.
REQ-009 IDLE: wren_i|rden_i sampled high -> latch addr_32b_i[ADDR_LSB+7:ADDR_LSB], din[7:0] and direction, go to ADDR; both high -> read.
REQ-010 Requests arriving outside IDLE SHALL be ignored (no queueing); busy_o signals this.
REQ-011 ADDR: can_ale=1 and can_ad_o=address for ALE_CYC cycles, can_ad_sel=0; then go to HOLD.
REQ-012 HOLD: can_ale=0 and address kept for HOLD_CYC cycles; then go to STROBE.
REQ-013 STROBE: can_cs_n=0 and can_rd_n=0 (read, can_ad_sel=1) or can_wr_n=0 (write, can_ad_o=data) for STB_CYC cycles.
REQ-014 A read SHALL capture can_ad_i on the clock edge ending the last STROBE cycle.
REQ-015 RECOVER: strobes and can_cs_n high, can_ad_o=0; can_ad_sel stays 1 after reads; lasts REC_CYC cycles, then IDLE with can_ad_sel=0.
REQ-016 dout_32b_valid_o SHALL pulse exactly in the first RECOVER cycle; dout_32b_o = captured byte (read) or 0 (write), held until the next completion.
REQ-017 Latency from request-sampling edge to valid pulse SHALL be ALE_CYC+HOLD_CYC+STB_CYC+1 cycles (11 at defaults); IDLE-to-IDLE period ALE_CYC+HOLD_CYC+STB_CYC+REC_CYC+1.
REQ-018 chip_rst_req_i SHALL set a pending flag; in IDLE, pending takes priority over a same-cycle read/write.
REQ-019 CHIP_RST: can_rst_n=0, can_cs_n=1, all strobes inactive, for CRST_CYC cycles, then RECOVER without a valid pulse.
REQ-020 can_int_n SHALL pass through a 2-flop synchroniser; a synchronised 1->0 edge sets irq_o.
REQ-021 irq_clr_i clears irq_o; simultaneous set and clear -> irq_o stays 1.
REQ-022 Phase counters SHALL be sized to the largest cycle parameter; every parameter SHALL be >=1, checked at elaboration.

Reset
REQ-023 On rst: can_ad_o=0, can_cs_n=1, can_ale=0, can_wr_n=1, can_rd_n=1, can_rst_n=0, can_ad_sel=0, dout_32b_o=0, dout_32b_valid_o=0, busy_o=1, irq_o=0, synchroniser flops=1, pending=0.
REQ-024 After rst is released the block SHALL enter CHIP_RST; any in-flight access is aborted without a completion pulse.

Structure
REQ-025 State enum and default timing constants SHALL live in shared package can_bus_pkg.
REQ-026 Synchroniser plus falling-edge detector SHALL be sub-module can_int_sync.

Verification
REQ-027 Reset release -> can_rst_n low 16 cycles, busy_o high, then IDLE with busy_o=0.
REQ-028 rden_i, addr 0x0000_0010, can_ad_i=0xA5 -> can_ad_o=0x04 while can_ale=1, valid pulse 11 cycles later, dout_32b_o=0x0000_00A5.
REQ-029 wren_i, addr 0x0000_0008, din 0x3C -> can_ad_o=0x02 then 0x3C during 6-cycle can_wr_n low, valid pulse with dout_32b_o=0.
REQ-030 Second rden_i 3 cycles after the first -> ignored, exactly one valid pulse and one strobe.
REQ-031 can_int_n falls -> irq_o high 3 cycles later; irq_clr_i coinciding with a new edge -> irq_o stays 1.
REQ-032 rst asserted mid-STROBE -> outputs reach REQ-023 values next cycle, no valid pulse, CHIP_RST follows.
